seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one 8-bit segment bus and four digit anodes between the four stopwatch digit encodings (MM:SS). It sits between the four display7seg outputs and the board pins. It sequences digit slots with an anti-ghosting blank interval, and snapshots all four digits once per frame so the display never shows a mixed frame such as 09→10. It also supports per-digit blanking and blinking for time-set/pause indication.

---
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 81 ++++++++
 tb/tb_seg_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit inputs, masks and multiplexed display pins of the scan scheduler.
interface seg_scan_ctrl_if;
   logic       en;
   logic [7:0] seg_d0;
   logic [7:0] seg_d1;
   logic [7:0] seg_d2;
   logic [7:0] seg_d3;
   logic [3:0] blank_mask;
   logic [3:0] blink_mask;
   logic [7:0] seg_out;
   logic [3:0] an_out;
   logic [1:0] digit_idx;
   logic       frame_done;
   modport master (
      output en, seg_d0, seg_d1, seg_d2, seg_d3, blank_mask, blink_mask,
      input  seg_out, an_out, digit_idx, frame_done
   );
   modport slave (
      input  en, seg_d0, seg_d1, seg_d2, seg_d3, blank_mask, blink_mask,
      output seg_out, an_out, digit_idx, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes four 7-segment digits onto one bus with blank
// intervals, per-frame snapshots and per-digit blanking/blinking.
module seg_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 1000,
   parameter int BLINK_DIV = 25000000
) (
   input logic           clk,
   input logic           rst,
   seg_scan_ctrl_if.slave bus
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
   state_t          state_q, state_d;
   logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
   logic [1:0]      digit_q, digit_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;
   logic [3:0][7:0] snap_seg_q, snap_seg_d;
   logic [3:0]      snap_blank_q, snap_blank_d;
   logic [3:0]      snap_blink_q, snap_blink_d;
   logic [7:0]      seg_out_q, seg_out_d;
   logic [3:0]      an_out_q, an_out_d;
   logic [1:0]      digit_idx_q, digit_idx_d;
   logic            frame_done_q, frame_done_d;
   logic            slot_last, blink_last, take_snap, lit;
   always_comb begin
      slot_last     = slot_cnt_q == SW'(SCAN_DIV - 1);
      blink_last    = blink_cnt_q == BW'(BLINK_DIV - 1);
      slot_cnt_d    = (!bus.en || state_q == IDLE || slot_last) ? '0 : slot_cnt_q + 1'b1;
      digit_d       = (!bus.en || state_q == IDLE) ? 2'd0 : digit_q + 2'(slot_last);
      state_d       = !bus.en ? IDLE : (int'(slot_cnt_d) < BLANK_CYC ? BLANK : DRIVE);
      // a new frame begins on the first enabled edge and on every digit-3 wrap
      take_snap     = bus.en && (state_q == IDLE || (slot_last && digit_q == 2'd3));
      snap_seg_d    = take_snap ? {bus.seg_d3, bus.seg_d2, bus.seg_d1, bus.seg_d0} : snap_seg_q;
      snap_blank_d  = take_snap ? bus.blank_mask : snap_blank_q;
      snap_blink_d  = take_snap ? bus.blink_mask : snap_blink_q;
      blink_cnt_d   = blink_last ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q ^ blink_last;
      lit           = bus.en && state_q == DRIVE && !snap_blank_q[digit_q]
                      && !(snap_blink_q[digit_q] && blink_phase_q);
      seg_out_d     = lit ? snap_seg_q[digit_q] : 8'hFF;
      an_out_d      = lit ? ~(4'b0001 << digit_q) : 4'hF;
      digit_idx_d   = bus.en ? digit_q : 2'd0;
      frame_done_d  = bus.en && state_q != IDLE && digit_q == 2'd3 && slot_last;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         slot_cnt_q    <= '0;
         digit_q       <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         snap_seg_q    <= {4{8'hFF}};
         snap_blank_q  <= 4'h0;
         snap_blink_q  <= 4'h0;
         seg_out_q     <= 8'hFF;
         an_out_q      <= 4'hF;
         digit_idx_q   <= 2'd0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_cnt_q    <= slot_cnt_d;
         digit_q       <= digit_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_seg_q    <= snap_seg_d;
         snap_blank_q  <= snap_blank_d;
         snap_blink_q  <= snap_blink_d;
         seg_out_q     <= seg_out_d;
         an_out_q      <= an_out_d;
         digit_idx_q   <= digit_idx_d;
         frame_done_q  <= frame_done_d;
      end
   end
   assign bus.seg_out    = seg_out_q;
   assign bus.an_out     = an_out_q;
   assign bus.digit_idx  = digit_idx_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + random stimulus against a position-based display model,
// covering BLANK_CYC=2 and BLANK_CYC=0 instances driven in lockstep.
module tb_seg_scan_ctrl;
   localparam int SD = 8, BC = 2, BD = 64;
   logic       clk = 0, rst = 1, en = 1;
   logic [7:0] d[4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
   logic [3:0] bm = 4'h0, km = 4'h0;
   int         tests = 0, fails = 0;
   string      tag = "reset";
   bit         m_act = 0, m_phase = 0;
   int         m_p = 0, m_bcnt = 0;
   logic [7:0] m_seg[4];
   logic [3:0] m_blank = 0, m_blink = 0;
   always #5 clk = ~clk;
   seg_scan_ctrl_if bus();
   seg_scan_ctrl_if bus0();
   assign bus.en = en;
   assign bus.seg_d0 = d[0];
   assign bus.seg_d1 = d[1];
   assign bus.seg_d2 = d[2];
   assign bus.seg_d3 = d[3];
   assign bus.blank_mask = bm;
   assign bus.blink_mask = km;
   assign bus0.en = en;
   assign bus0.seg_d0 = d[0];
   assign bus0.seg_d1 = d[1];
   assign bus0.seg_d2 = d[2];
   assign bus0.seg_d3 = d[3];
   assign bus0.blank_mask = bm;
   assign bus0.blink_mask = km;
   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_DIV(BD)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   // expected pins {seg, an, idx, fd} for the edge about to happen, from scan position m_p
   function automatic logic [14:0] expect_out(int bc);
      int dg, k;
      bit lit;
      if (rst || !en || !m_act) return {8'hFF, 4'hF, 2'd0, 1'b0};
      dg  = (m_p / SD) % 4;
      k   = m_p % SD;
      lit = k >= bc && !m_blank[dg] && !(m_blink[dg] && m_phase);
      return {lit ? m_seg[dg] : 8'hFF, lit ? ~(4'b0001 << dg) : 4'hF, 2'(dg), 1'(dg == 3 && k == SD - 1)};
   endfunction
   task automatic chk(string what, logic [7:0] got, logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s/%s got %h exp %h", tag, what, got, exp);
      end
   endtask
   task automatic tick();
      logic [14:0] e, e0;
      e  = expect_out(BC);
      e0 = expect_out(0);
      if (rst) begin
         m_bcnt = 0; m_phase = 0; m_act = 0; m_p = 0; m_blank = 0; m_blink = 0;
         for (int i = 0; i < 4; i++) m_seg[i] = 8'hFF;
      end else begin
         if (m_bcnt == BD - 1) begin m_bcnt = 0; m_phase = !m_phase; end
         else m_bcnt++;
         if (!en) m_act = 0;
         else begin
            m_p   = m_act ? m_p + 1 : 0;
            m_act = 1;
            if (m_p % (4 * SD) == 0) begin
               for (int i = 0; i < 4; i++) m_seg[i] = d[i];
               m_blank = bm;
               m_blink = km;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("seg", bus.seg_out, e[14:7]);
      chk("an", 8'(bus.an_out), 8'(e[6:3]));
      chk("idx", 8'(bus.digit_idx), 8'(e[2:1]));
      chk("fd", 8'(bus.frame_done), 8'(e[0]));
      chk("seg0", bus0.seg_out, e0[14:7]);
      chk("an0", 8'(bus0.an_out), 8'(e0[6:3]));
      chk("idx0", 8'(bus0.digit_idx), 8'(e0[2:1]));
      chk("fd0", 8'(bus0.frame_done), 8'(e0[0]));
   endtask
   initial begin
      repeat (3) tick();
      chk("rst_an", 8'(bus.an_out), 8'h0F);
      rst = 0; tag = "scan";
      repeat (4) tick();
      chk("first_an", 8'(bus.an_out), 8'h0E);
      chk("first_seg", bus.seg_out, 8'hC0);
      repeat (28) tick();
      tick();
      chk("first_fd", 8'(bus.frame_done), 8'h01);
      tag = "snapshot";
      repeat (18) tick();
      d[0] = 8'hF9; d[1] = 8'hC0;
      repeat (17) tick();
      chk("new_d0", bus.seg_out, 8'hF9);
      chk("new_an", 8'(bus.an_out), 8'h0E);
      repeat (20) tick();
      tag = "blank";
      bm = 4'b1000;
      repeat (80) tick();
      bm = 4'h0;
      tag = "blink";
      rst = 1; km = 4'b0001;
      tick();
      rst = 0;
      repeat (260) tick();
      tag = "endrop";
      km = 4'h0; en = 0;
      tick();
      en = 1;
      repeat (12) tick();
      en = 0;
      tick();
      chk("drop_an", 8'(bus.an_out), 8'h0F);
      chk("drop_seg", bus.seg_out, 8'hFF);
      chk("drop_idx", 8'(bus.digit_idx), 8'h00);
      chk("drop_fd", 8'(bus.frame_done), 8'h00);
      en = 1;
      repeat (2) tick();
      chk("bc0_an", 8'(bus0.an_out), 8'h0E);
      chk("bc2_an", 8'(bus.an_out), 8'h0F);
      repeat (40) tick();
      tag = "random";
      repeat (3000) begin
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         if ($urandom_range(0, 31) == 0) bm = 4'($urandom);
         if ($urandom_range(0, 31) == 0) km = 4'($urandom);
         en  = en ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 3) == 0);
         rst = $urandom_range(0, 499) == 0;
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
